sigmoid_share_arbiter: RTL and testbench
========================================

# sigmoid_share_arbiter

- Shares one ap_ctrl_hs sigmoid core (SIGMOID, e.g. `grp_SIGMOID_fu_*`) between up to NUM_REQ layer engines of the LeNet-5 datapath (calculateLayer2/3/4 and similar).
- Arbitrates requests round-robin and holds exactly one transaction outstanding.
- Replays the core's ap_start/ap_ready/ap_done handshake back to the granted requester, so every requester still sees a private ap_ctrl_hs sigmoid.

## Interface
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, width of the sigmoid argument and result (opaque bit pattern).
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_start  in  NUM_REQ  per-requester ap_start; held high until that requester's req_ready pulses.
- req_x  in  NUM_REQ×DATA_W  per-requester argument; valid while req_start is high.
- req_ready  out  NUM_REQ  one-hot ap_ready pulse to the granted requester.
- req_done  out  NUM_REQ  one-hot ap_done pulse to the granted requester.
- req_y  out  DATA_W  shared result bus; valid while req_done pulses, then holds until the next result.
- core_start  out  1  ap_start to the sigmoid core.
- core_x  out  DATA_W  argument to the core; the latched value of req_x from the granted requester.
- core_ready  in  1  core ap_ready pulse.
- core_done  in  1  core ap_done pulse.
- core_y  in  DATA_W  core return value; valid while core_done is high.
- arb_busy  out  1  high in states ISSUE and WAIT.
- last_grant  out  $clog2(NUM_REQ)  index of the most recent grant.

## Operation
- FSM states:
  - IDLE: if any req_start bit is high, pick the first requester at or after rr_ptr (wrapping) whose bit is high. Latch grant = that index and x_q = req_x[grant]. Set rr_ptr <= (grant+1) mod NUM_REQ. Go to ISSUE. With no request, stay in IDLE.
  - ISSUE: drive core_start=1 and core_x=x_q. On core_ready, go to WAIT; if core_done is also high in that cycle, treat it as a completion and go to IDLE.
  - WAIT: core_start=0. On core_done, go to IDLE.
- Forwarding:
  - req_ready[grant] = core_ready & (state==ISSUE). This is combinational, in the same cycle as core_ready.
  - Completion is registered: req_done[grant] pulses for exactly 1 cycle, the cycle after core_done. req_y <= core_y in the same update.
- Only the granted requester ever sees ready or done. Non-granted req_start bits stay pending with no response.
- Protocol violation: if the granted requester drops req_start before its ready, the transaction still completes using x_q, and its ready/done still pulse.
- A core_done seen in IDLE is spurious and is ignored; no req_done is produced.
- Reset values (asynchronous, ap_rst_n=0), applied immediately mid-transaction as well:
  - state=IDLE, rr_ptr=0, grant=0, x_q=0.
  - req_ready=0, req_done=0, req_y=0, core_start=0, arb_busy=0, last_grant=0.
- After reset deassertion, requests that are still pending are re-arbitrated from rr_ptr=0.

## Timing
- Request high in IDLE at cycle t:
  - grant latched at edge t+1;
  - core_start high from t+1 until the core_ready cycle inclusive.
- core_done at cycle d: req_done and req_y are valid at cycle d+1; state is IDLE at d+1.
- Next grant is latched at edge d+2, giving core_start again at d+2.
- Minimum turnaround, for a core that asserts ready and done in its first start cycle: 2 cycles per transaction (ISSUE, IDLE/done).
- Fairness: a requester that stays pending waits at most NUM_REQ−1 foreign transactions.

## Structure
- Package sigmoid_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  - localparam defaults for NUM_REQ and DATA_W.
- One sub-module, sigmoid_rr_pick:
  - purely combinational;
  - inputs: request vector, rr_ptr;
  - outputs: grant index, any_req.
- The top holds the FSM, the x_q / req_y registers and the response demultiplexing.

## Test plan
- Single request: req_start[2]=1, x=32'h3F800000; core model with latency 5 returns 32'h3F3B26A3.
  - Expect req_ready[2] in the core_ready cycle.
  - Expect req_done[2] exactly 1 cycle after core_done, with req_y=32'h3F3B26A3.
  - Expect no pulses on other bits.
- All four requesters asserted at once, held until served: grants in order 0,1,2,3. Re-assert 1 and 3 only: order 1,3 (rr_ptr=0 after 3, so 1 first).
- Core with ready and done in the same cycle: transactions complete 2 cycles apart; each req_done carries its own result.
- Requester 0 re-requests right after every done while 1 stays pending: the sequence alternates 0,1,0,1 and 1 never waits more than one transaction.
- Reset pulled low in WAIT: all outputs are 0 immediately. A later core_done in IDLE produces no req_done. After reset release, the first grant goes to the lowest pending index.
- Requester drops req_start in ISSUE: transaction still completes with the latched x_q; done goes to the original grant index.

Source files
------------

// File: rtl/sigmoid_arb_pkg.sv
// Shared types and defaults for the sigmoid-core arbiter.
// Used by the arbiter top and its round-robin picker.
package sigmoid_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;

endpackage

// File: rtl/sigmoid_rr_pick.sv
// Round-robin picker: first requester at or after rr_ptr (wrapping).
// Purely combinational.
module sigmoid_rr_pick
  import sigmoid_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0] idx_s;
  logic             hit_s;

  // scan from rr_ptr upward, keeping the first pending index
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s   = IDX_W'((32'(rr_ptr) + 32'(i)) % 32'(NUM_REQ));
      hit_s   = !any_req && req[idx_s];
      grant   = hit_s ? idx_s : grant;
      any_req = any_req | hit_s;
    end
  end

endmodule

// File: rtl/sigmoid_share_arbiter.sv
// Shares one ap_ctrl_hs sigmoid core among NUM_REQ requesters, one
// transaction outstanding, replaying ready/done to the granted requester.
module sigmoid_share_arbiter
  import sigmoid_arb_pkg::*;
#(
  parameter int  NUM_REQ = NUM_REQ_DEF,
  parameter int  DATA_W  = DATA_W_DEF,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_REQ-1:0]        req_start,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         req_y,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_x,
  input  logic                      core_ready,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_y,
  output logic                      arb_busy,
  output logic [IDX_W-1:0]          last_grant
);

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_t          state_r;
  logic [IDX_W-1:0]    rr_ptr_r;
  logic [IDX_W-1:0]    grant_r;
  logic [DATA_W-1:0]   x_q_r;
  logic [NUM_REQ-1:0]  req_done_r;
  logic [DATA_W-1:0]   req_y_r;
  logic                core_start_r;
  logic                busy_r;

  logic [IDX_W-1:0]    pick_s;
  logic                any_req_s;
  logic [DATA_W-1:0]   x_sel_s;
  logic [NUM_REQ-1:0]  grant_onehot_s;

  sigmoid_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req_start),
    .rr_ptr  (rr_ptr_r),
    .grant   (pick_s),
    .any_req (any_req_s)
  );

  // argument of the requester about to be granted
  always_comb begin
    x_sel_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      x_sel_s = (pick_s == IDX_W'(k)) ? req_x[k*DATA_W +: DATA_W] : x_sel_s;
    end
  end

  // one-hot decode of the current grant for response steering
  always_comb begin
    grant_onehot_s          = '0;
    grant_onehot_s[grant_r] = 1'b1;
  end

  // ready is forwarded in the same cycle the core accepts the start
  always_comb begin
    if (state_r == ISSUE && core_ready) begin
      req_ready = grant_onehot_s;
    end else begin
      req_ready = '0;
    end
  end

  // arbitration FSM with registered start/busy/done/result
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      grant_r      <= '0;
      x_q_r        <= '0;
      req_done_r   <= '0;
      req_y_r      <= '0;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      req_done_r <= '0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r      <= pick_s;
            x_q_r        <= x_sel_s;
            rr_ptr_r     <= (pick_s == IDX_LAST) ? '0 : pick_s + IDX_ONE;
            core_start_r <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (core_ready) begin
            core_start_r <= 1'b0;
            // a core may finish in its accept cycle
            if (core_done) begin
              req_done_r <= grant_onehot_s;
              req_y_r    <= core_y;
              busy_r     <= 1'b0;
              state_r    <= IDLE;
            end else begin
              state_r <= WAIT;
            end
          end else begin
            state_r <= ISSUE;
          end
        end
        WAIT: begin
          if (core_done) begin
            req_done_r <= grant_onehot_s;
            req_y_r    <= core_y;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          core_start_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign req_done   = req_done_r;
  assign req_y      = req_y_r;
  assign core_start = core_start_r;
  assign core_x     = x_q_r;
  assign arb_busy   = busy_r;
  assign last_grant = grant_r;

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Directed bench for sigmoid_share_arbiter with a small ap_ctrl_hs core model.
module tb_sigmoid_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 2;

  logic                      ap_clk = 1'b0;
  logic                      ap_rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_start = '0;
  logic [NUM_REQ*DATA_W-1:0] req_x = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_done;
  logic [DATA_W-1:0]         req_y;
  logic                      core_start;
  logic [DATA_W-1:0]         core_x;
  logic                      core_ready = 1'b0;
  logic                      core_done = 1'b0;
  logic [DATA_W-1:0]         core_y = '0;
  logic                      arb_busy;
  logic [IDX_W-1:0]          last_grant;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sigmoid_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .req_start  (req_start),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .req_done   (req_done),
    .req_y      (req_y),
    .core_start (core_start),
    .core_x     (core_x),
    .core_ready (core_ready),
    .core_done  (core_done),
    .core_y     (core_y),
    .arb_busy   (arb_busy),
    .last_grant (last_grant)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  function automatic logic [31:0] sig_ref(input logic [31:0] x);
    if (x == 32'h3F80_0000) return 32'h3F3B_26A3;
    return {x[15:0], x[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // core model: ready after m_rdy_dly start cycles, done m_lat cycles after ready
  int   m_lat = 1, m_rdy_dly = 0, m_cnt = 0, m_wait = 0;
  bit   m_busy = 1'b0;
  logic [31:0] m_res = '0;
  always @(posedge ap_clk) begin
    #1;
    core_ready = 1'b0;
    core_done  = 1'b0;
    if (m_busy) begin
      if (m_cnt == 0) begin
        core_done = 1'b1; core_y = m_res; m_busy = 1'b0;
      end else m_cnt--;
    end else if (core_start) begin
      if (m_wait < m_rdy_dly) m_wait++;
      else begin
        m_wait = 0; core_ready = 1'b1; m_res = sig_ref(core_x);
        if (m_lat == 0) begin core_done = 1'b1; core_y = m_res; end
        else begin m_busy = 1'b1; m_cnt = m_lat - 1; end
      end
    end else m_wait = 0;
  end

  int          start_cyc;
  int          core_rdy_q[$], core_done_q[$], rdy_cyc_q[$], done_cyc_q[$];
  logic [3:0]  rdy_val_q[$], done_val_q[$];
  logic [31:0] done_y_q[$];
  int          rereq_left[NUM_REQ];
  logic [31:0] xv[NUM_REQ];

  task automatic clear_log();
    start_cyc = -1;
    core_rdy_q.delete(); core_done_q.delete(); rdy_cyc_q.delete();
    done_cyc_q.delete(); rdy_val_q.delete(); done_val_q.delete(); done_y_q.delete();
  endtask

  task automatic set_x(input int k, input logic [31:0] v);
    xv[k] = v;
    req_x[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    req_start = '0;
    req_x = '0;
    m_busy = 1'b0; m_wait = 0; m_rdy_dly = 0;
    for (int k = 0; k < NUM_REQ; k++) rereq_left[k] = 0;
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #2;
    clear_log();
  endtask

  // requester behaviour: drop start at ready, optionally re-request at done
  task automatic run(input int max_cyc, input int want, output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < max_cyc; n++) begin
      @(posedge ap_clk); #2;
      if (core_start && start_cyc < 0) start_cyc = cyc;
      if (core_ready) core_rdy_q.push_back(cyc);
      if (core_done) core_done_q.push_back(cyc);
      if (req_ready != '0) begin rdy_val_q.push_back(req_ready); rdy_cyc_q.push_back(cyc); end
      if (req_done != '0) begin
        done_val_q.push_back(req_done); done_y_q.push_back(req_y); done_cyc_q.push_back(cyc);
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_ready[k]) req_start[k] = 1'b0;
        if (req_done[k] && rereq_left[k] > 0) begin req_start[k] = 1'b1; rereq_left[k]--; end
      end
      if (done_val_q.size() >= want) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    req_start = 4'b1111;
    repeat (2) @(posedge ap_clk);
    #2;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (req_done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", req_done); end
    checks++; if (req_y !== 32'h0) begin errors++; $display("FAIL reset_y: got %h want 0", req_y); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", core_start); end
    checks++; if (core_x !== 32'h0) begin errors++; $display("FAIL reset_core_x: got %h want 0", core_x); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", arb_busy); end
    checks++; if (last_grant !== 2'd0) begin errors++; $display("FAIL reset_last_grant: got %0d want 0", last_grant); end
    req_start = '0;
  endtask

  task automatic test_single();
    bit to; int t;
    do_reset();
    m_lat = 5;
    for (int k = 0; k < NUM_REQ; k++) set_x(k, 32'h1111_0000 + 32'(k));
    set_x(2, 32'h3F80_0000);
    t = cyc;
    req_start = 4'b0100;
    run(40, 1, to);
    repeat (3) begin
      @(posedge ap_clk); #2;
      if (req_ready != '0) rdy_val_q.push_back(req_ready);
      if (req_done != '0) done_val_q.push_back(req_done);
    end
    checks++; if (to) begin errors++; $display("FAIL single_timeout: got no req_done within 40 cycles"); end
    checks++; if (start_cyc != t + 1) begin errors++; $display("FAIL single_start_cycle: got %0d want %0d", start_cyc, t + 1); end
    checks++; if (rdy_val_q.size() != 1 || rdy_val_q[0] !== 4'b0100) begin errors++; $display("FAIL single_ready: got %0d pulses want one 0100", rdy_val_q.size()); end
    checks++; if (rdy_cyc_q.size() < 1 || core_rdy_q.size() < 1 || rdy_cyc_q[0] != core_rdy_q[0]) begin errors++; $display("FAIL single_ready_cycle: req_ready not in core_ready cycle"); end
    checks++; if (core_done_q.size() < 1 || core_rdy_q.size() < 1 || core_done_q[0] - core_rdy_q[0] != 5) begin errors++; $display("FAIL single_core_latency: done/ready queues %0d/%0d", core_done_q.size(), core_rdy_q.size()); end
    checks++; if (done_val_q.size() != 1 || done_val_q[0] !== 4'b0100) begin errors++; $display("FAIL single_done: got %0d pulses want one 0100", done_val_q.size()); end
    checks++; if (done_cyc_q.size() < 1 || core_done_q.size() < 1 || done_cyc_q[0] != core_done_q[0] + 1) begin errors++; $display("FAIL single_done_cycle: req_done not 1 cycle after core_done"); end
    checks++; if (done_y_q.size() < 1 || done_y_q[0] !== 32'h3F3B_26A3) begin errors++; $display("FAIL single_y: got %h want 3f3b26a3", (done_y_q.size() > 0) ? done_y_q[0] : 32'hx); end
    checks++; if (req_y !== 32'h3F3B_26A3) begin errors++; $display("FAIL single_y_hold: got %h want 3f3b26a3", req_y); end
    checks++; if (last_grant !== 2'd2) begin errors++; $display("FAIL single_last_grant: got %0d want 2", last_grant); end
  endtask

  task automatic test_all_four();
    bit to;
    do_reset();
    m_lat = 1;
    for (int k = 0; k < NUM_REQ; k++) set_x(k, 32'h4000_0000 + 32'(k) * 32'h0111_0000);
    req_start = 4'b1111;
    run(80, 4, to);
    checks++; if (to) begin errors++; $display("FAIL all4_timeout: got %0d dones want 4", done_val_q.size()); end
    for (int i = 0; i < 4 && i < done_val_q.size(); i++) begin
      checks++; if (done_val_q[i] !== (4'b0001 << i)) begin errors++; $display("FAIL all4_order[%0d]: got %b want %b", i, done_val_q[i], 4'b0001 << i); end
      checks++; if (done_y_q[i] !== sig_ref(xv[i])) begin errors++; $display("FAIL all4_y[%0d]: got %h want %h", i, done_y_q[i], sig_ref(xv[i])); end
    end
    clear_log();
    req_start = 4'b1010;
    run(40, 2, to);
    checks++; if (to || done_val_q.size() < 2) begin errors++; $display("FAIL reassert_timeout: got %0d dones want 2", done_val_q.size()); end
    else begin
      checks++; if (done_val_q[0] !== 4'b0010 || done_val_q[1] !== 4'b1000) begin errors++; $display("FAIL reassert_order: got %b,%b want 0010,1000", done_val_q[0], done_val_q[1]); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    do_reset();
    m_lat = 0;
    for (int k = 0; k < NUM_REQ; k++) set_x(k, 32'hBEEF_0000 ^ (32'(k) << 4));
    req_start = 4'b1111;
    run(40, 4, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout: got %0d dones want 4", done_val_q.size()); end
    for (int i = 1; i < done_cyc_q.size(); i++) begin
      checks++; if (done_cyc_q[i] - done_cyc_q[i-1] != 2) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 2", i, done_cyc_q[i] - done_cyc_q[i-1]); end
    end
    for (int i = 0; i < done_y_q.size(); i++) begin
      checks++; if (done_y_q[i] !== sig_ref(xv[i])) begin errors++; $display("FAIL b2b_y[%0d]: got %h want %h", i, done_y_q[i], sig_ref(xv[i])); end
    end
  endtask

  task automatic test_fairness();
    bit to;
    logic [3:0] exp_q[6] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
    do_reset();
    m_lat = 2;
    set_x(0, 32'h0000_1234); set_x(1, 32'h0000_5678);
    rereq_left[0] = 2; rereq_left[1] = 2;
    req_start = 4'b0011;
    run(120, 6, to);
    checks++; if (to) begin errors++; $display("FAIL fair_timeout: got %0d dones want 6", done_val_q.size()); end
    for (int i = 0; i < 6 && i < done_val_q.size(); i++) begin
      checks++; if (done_val_q[i] !== exp_q[i]) begin errors++; $display("FAIL fair_order[%0d]: got %b want %b", i, done_val_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to; bit seen = 1'b0;
    do_reset();
    m_lat = 8;
    set_x(2, 32'h1234_5678);
    req_start = 4'b0100;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge ap_clk); #2;
      if (req_ready[2]) begin seen = 1'b1; req_start = '0; end
    end
    repeat (2) @(posedge ap_clk);
    #2;
    checks++; if (!seen || arb_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", arb_busy); end
    ap_rst_n = 1'b0;
    #1;
    checks++; if (arb_busy !== 1'b0 || core_start !== 1'b0 || last_grant !== 2'd0) begin errors++; $display("FAIL mid_reset_ctrl: busy %b start %b grant %0d want 0 0 0", arb_busy, core_start, last_grant); end
    checks++; if (req_done !== 4'b0000 || req_ready !== 4'b0000 || core_x !== 32'h0) begin errors++; $display("FAIL mid_reset_data: done %b ready %b core_x %h want zeros", req_done, req_ready, core_x); end
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
    clear_log();
    run(12, 1, to);
    checks++; if (core_done_q.size() != 1) begin errors++; $display("FAIL mid_spurious_seen: got %0d core_done want 1", core_done_q.size()); end
    checks++; if (done_val_q.size() != 0) begin errors++; $display("FAIL mid_spurious_done: got %0d req_done want 0", done_val_q.size()); end
    clear_log();
    m_lat = 1;
    set_x(1, 32'h0BAD_F00D); set_x(3, 32'h0000_0003);
    req_start = 4'b1010;
    run(40, 1, to);
    checks++; if (done_val_q.size() < 1 || done_val_q[0] !== 4'b0010) begin errors++; $display("FAIL mid_rearb: got %b want 0010", (done_val_q.size() > 0) ? done_val_q[0] : 4'bx); end
  endtask

  task automatic test_drop();
    bit to;
    do_reset();
    m_lat = 3; m_rdy_dly = 2;
    set_x(3, 32'hC000_0000);
    req_start = 4'b1000;
    @(posedge ap_clk); #2;
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL drop_issue: got core_start %b want 1", core_start); end
    req_start = 4'b0000;
    req_x[3*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    run(40, 1, to);
    checks++; if (rdy_val_q.size() < 1 || rdy_val_q[0] !== 4'b1000) begin errors++; $display("FAIL drop_ready: got %b want 1000", (rdy_val_q.size() > 0) ? rdy_val_q[0] : 4'bx); end
    checks++; if (done_val_q.size() < 1 || done_val_q[0] !== 4'b1000) begin errors++; $display("FAIL drop_done: got %b want 1000", (done_val_q.size() > 0) ? done_val_q[0] : 4'bx); end
    checks++; if (done_y_q.size() < 1 || done_y_q[0] !== sig_ref(32'hC000_0000)) begin errors++; $display("FAIL drop_y: got %h want %h", (done_y_q.size() > 0) ? done_y_q[0] : 32'hx, sig_ref(32'hC000_0000)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
    test_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
